rv32i_single_cycle_core: RTL and testbench
==========================================

Name: rv32i_single_cycle_core

Overview:
- Single-cycle RV32I integer CPU core for the didactic RISC-V platform.
- Fetches one 32-bit instruction per clock from an external instruction ROM and executes it in the same cycle.
- Accesses an external word-addressed data RAM through a combinational-read, synchronous-write interface.
- The top-level bench instantiates it between the ROM and RAM blocks.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first instruction fetched after reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- instruction  in  32  instruction word at rom_addr; combinational from the ROM.
- mem_rd_data  in  32  data word at mem_addr; combinational from the RAM.
- rom_addr  out  32  program counter, byte address.
- mem_addr  out  32  data byte address (ALU result) for loads and stores.
- mem_wr_data  out  32  store data (rs2 value).
- mem_wr_sig  out  1  high during a store; RAM writes on that rising clk edge.

Behaviour:
- Reset (asserted asynchronously):
  - PC = RESET_PC.
  - All 32 registers x0..x31 = 0.
  - mem_wr_sig = 0 while reset is high.
  - Remaining outputs are combinational from the cleared state.
- Cycle:
  - rom_addr = PC.
  - Decode, register read, ALU, memory access and writeback all complete combinationally.
  - On the rising edge: PC <= next_pc; register rd <= result when the instruction writes rd and rd != 0.
  - RAM writes on the same edge.
  - CPI = 1 for every instruction.
- next_pc:
  - PC+4 by default.
  - JAL: PC+imm_j.
  - JALR: (rs1+imm_i) & ~1.
  - Taken branch: PC+imm_b.
  - All arithmetic is 32-bit and wraps modulo 2^32.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - LW, SW.
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI.
  - ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
- Immediates are sign-extended from bit 31. Shift amount = low 5 bits.
- Register file:
  - 32x32 array named registers, in sub-module instance reg_file_inst.
  - Two combinational read ports, one synchronous write port.
  - x0 reads 0 and writes to x0 are discarded.
  - A read and a write of the same register in one cycle returns the old value.
- Loads/stores:
  - Word only.
  - Byte/half-word funct3 encodings are executed as word accesses.
  - mem_addr = rs1+imm, passed unaligned as-is; the RAM ignores addr[1:0].
  - mem_wr_sig is asserted only for the store opcode.
- JAL/JALR write PC+4 to rd.
- Unknown/unsupported opcodes (FENCE, ECALL, EBREAK, CSR, all-zero word): treated as NOP, i.e. PC+4 with no register or memory write.
- SUB/SRA are selected by funct7 bit 5. Other funct7 values decode as the base op.
- Reset mid-program: state returns to reset values immediately. Execution restarts at RESET_PC on the first edge after deassertion.

Decomposition:
- Shared package/header holds:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC);
  - funct3 codes;
  - ALU operation enum;
  - RESET_PC.
- One sub-module, reg_file, instance name reg_file_inst, with array registers.
- ALU and decoder stay inside the core.

Test Plan:
- Reset held 1 cycle, then released:
  - rom_addr = 0 during reset.
  - Advances 0,4,8 on successive edges.
  - All registers read 0.
- ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x2,x1; SLT x5,x2,x1; SLTU x6,x2,x1 -> x3=2, x4=-8, x5=1, x6=0.
- SW x1,8(x0) then LW x7,8(x0):
  - mem_wr_sig = 1 for exactly one cycle with mem_addr=8, mem_wr_data=5.
  - x7 = 5 afterwards.
- Branch/jump check:
  - BEQ taken skips the next instruction; BNE not-taken falls through.
  - JAL x1,+8 sets x1 = PC+4.
  - JALR x0,0(x1) returns to that address.
- ADDI x0,x0,7 -> x0 still 0.
- Recursive sum-of-n program (n=10; stack in RAM via sp, JAL/JALR recursion) -> register x29 = 55 within 500 cycles.

Source files
------------

// File: rtl/rv32i_single_cycle_core_pkg.sv
// Shared definitions for the single-cycle RV32I core: base opcodes,
// funct3 codes for ALU and branch instructions, the ALU operation enum
// and the default reset program counter.
package rv32i_single_cycle_core_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // ALU funct3 codes (OP and OP_IMM)
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // Branch funct3 codes
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

endpackage

// File: rtl/rv32i_single_cycle_core_reg_file.sv
// 32x32 integer register file: two combinational read ports and one
// write port updated on the rising clock edge. x0 always reads zero and
// writes to it are dropped. A same-cycle read of the register being
// written returns the old contents.
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high clear of all registers
//   i_rs1_addr/o_rs1_data  read port 1
//   i_rs2_addr/o_rs2_data  read port 2
//   i_we, i_rd_addr, i_rd_data  write port
module rv32i_single_cycle_core_reg_file (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  input  logic        i_we,
  input  logic [4:0]  i_rd_addr,
  input  logic [31:0] i_rd_data,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data
);

  logic [31:0] registers [32];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (i_we && (i_rd_addr != 5'd0)) begin
      registers[i_rd_addr] <= i_rd_data;
    end
  end

  assign o_rs1_data = (i_rs1_addr == 5'd0) ? '0 : registers[i_rs1_addr];
  assign o_rs2_data = (i_rs2_addr == 5'd0) ? '0 : registers[i_rs2_addr];

endmodule

// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I core. Each clock one instruction is fetched from the
// ROM at rom_addr (= PC), decoded, executed and retired; loads read the
// RAM combinationally and stores write it on the same rising edge.
// Unsupported opcodes retire as NOPs.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   instruction         instruction word at rom_addr
//   mem_rd_data         RAM word at mem_addr
//   rom_addr            program counter (byte address)
//   mem_addr            load/store byte address (rs1 + imm)
//   mem_wr_data         store data (rs2)
//   mem_wr_sig          store strobe, forced low during reset
module rv32i_single_cycle_core #(
  parameter logic [31:0] RESET_PC = rv32i_single_cycle_core_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] mem_rd_data,
  output logic [31:0] rom_addr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_sig
);

  import rv32i_single_cycle_core_pkg::*;

  logic [31:0] r_pc;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_rs1_data, w_rs2_data;
  logic [31:0] w_alu_b, w_alu_y, w_pc_plus4, w_wb_data, w_next_pc;
  alu_op_e     w_alu_op;
  logic        w_rd_we, w_mem_we;

  function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a,
                                      input logic [31:0] b);
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic [31:0]        y;
    a_s = a;
    b_s = b;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SLT:  y = {31'b0, a_s < b_s};
      ALU_SLTU: y = {31'b0, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = a_s >>> b[4:0];
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = a + b;
    endcase
    return y;
  endfunction

  // alt is instruction bit 30; it selects SUB/SRA, all other funct7 bits ignored
  function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      F3_AND:     op = ALU_AND;
      default:    op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Reserved branch funct3 encodings (010, 011) never branch.
  function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic               t;
    a_s = a;
    b_s = b;
    case (f3)
      F3_BEQ:  t = (a == b);
      F3_BNE:  t = (a != b);
      F3_BLT:  t = (a_s < b_s);
      F3_BGE:  t = (a_s >= b_s);
      F3_BLTU: t = (a < b);
      F3_BGEU: t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  assign w_opcode = instruction[6:0];
  assign w_rd     = instruction[11:7];
  assign w_funct3 = instruction[14:12];
  assign w_rs1    = instruction[19:15];
  assign w_rs2    = instruction[24:20];

  assign w_imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign w_imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign w_imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
  assign w_imm_u = {instruction[31:12], 12'b0};
  assign w_imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

  rv32i_single_cycle_core_reg_file reg_file_inst (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_rs1_addr (w_rs1),
    .i_rs2_addr (w_rs2),
    .i_we       (w_rd_we),
    .i_rd_addr  (w_rd),
    .i_rd_data  (w_wb_data),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data)
  );

  // Control decode; kept separate from writeback/next-PC so the ALU sits
  // between two independent combinational blocks.
  always_comb begin
    w_alu_op = ALU_ADD;
    w_alu_b  = w_imm_i;
    w_rd_we  = 1'b0;
    w_mem_we = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_alu_b  = w_rs2_data;
        w_alu_op = alu_sel(w_funct3, instruction[30]);
        w_rd_we  = 1'b1;
      end
      OPC_OP_IMM: begin
        // bit 30 of an I-immediate only means SRAI for the right-shift funct3
        w_alu_op = alu_sel(w_funct3, instruction[30] && (w_funct3 == F3_SRL_SRA));
        w_rd_we  = 1'b1;
      end
      OPC_LOAD:  w_rd_we = 1'b1;
      OPC_STORE: begin
        w_alu_b  = w_imm_s;
        w_mem_we = 1'b1;
      end
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: w_rd_we = 1'b1;
      default: ;
    endcase
  end

  assign w_alu_y    = alu(w_alu_op, w_rs1_data, w_alu_b);
  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    w_wb_data = w_alu_y;
    w_next_pc = w_pc_plus4;
    case (w_opcode)
      OPC_LOAD:   w_wb_data = mem_rd_data;
      OPC_BRANCH: if (br_taken(w_funct3, w_rs1_data, w_rs2_data)) w_next_pc = r_pc + w_imm_b;
      OPC_JAL: begin
        w_wb_data = w_pc_plus4;
        w_next_pc = r_pc + w_imm_j;
      end
      OPC_JALR: begin
        w_wb_data = w_pc_plus4;
        w_next_pc = w_alu_y & ~32'd1;
      end
      OPC_LUI:   w_wb_data = w_imm_u;
      OPC_AUIPC: w_wb_data = r_pc + w_imm_u;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pc <= RESET_PC;
    else       r_pc <= w_next_pc;
  end

  assign rom_addr    = r_pc;
  assign mem_addr    = w_alu_y;
  assign mem_wr_data = w_rs2_data;
  assign mem_wr_sig  = w_mem_we & ~reset;

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Bench for rv32i_single_cycle_core: a 256-word ROM and 256-word RAM
// (both indexed by address bits [9:2]) surround the core. For each program
// an instruction-level reference model precomputes the per-cycle trace
// (PC, store strobe/address/data) into a queue; a negedge monitor pops and
// compares it while the core runs. Architectural registers are compared
// with the model at the end of each program.
module tb_rv32i_single_cycle_core;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ram_clr = 1'b0;
  logic        mon_en = 1'b0;
  logic [31:0] instruction, mem_rd_data, rom_addr, mem_addr, mem_wr_data;
  logic        mem_wr_sig;

  logic [31:0] rom [256];
  logic [31:0] ram [256];

  logic [31:0] m_pc;
  logic [31:0] m_reg [32];
  logic [31:0] m_ram [256];

  exp_t exp_q[$];
  exp_t mon_e;
  int   errs = 0;
  int   checks = 0;

  rv32i_single_cycle_core #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .mem_rd_data (mem_rd_data),
    .rom_addr    (rom_addr),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_sig  (mem_wr_sig)
  );

  always #5 clk = ~clk;

  assign instruction = rom[rom_addr[9:2]];
  assign mem_rd_data = ram[mem_addr[9:2]];

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
    end else if (mem_wr_sig) begin
      ram[mem_addr[9:2]] <= mem_wr_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction
  function automatic logic [31:0] enc_u(input logic [31:0] imm, input logic [4:0] rd,
      input logic [6:0] op);
    return {imm[19:0], rd, op};
  endfunction

  // ---------------- reference model: one instruction ----------------
  task automatic model_step(output exp_t e);
    logic [31:0] ins, a, b, ii, y, res, nxt;
    logic [6:0]  op;
    logic [4:0]  rd, sh;
    logic        wr, tk;
    ins = rom[m_pc[9:2]];
    op  = ins[6:0];
    rd  = ins[11:7];
    a   = m_reg[ins[19:15]];
    b   = m_reg[ins[24:20]];
    ii  = int'($signed(ins[31:20]));
    nxt = m_pc + 4;
    res = 32'h0;
    wr  = 1'b0;
    tk  = 1'b0;
    e.pc = m_pc; e.we = 1'b0; e.addr = 32'h0; e.data = 32'h0;
    case (op)
      7'h37: begin res = {ins[31:12], 12'h0}; wr = 1'b1; end
      7'h17: begin res = m_pc + {ins[31:12], 12'h0}; wr = 1'b1; end
      7'h6f: begin
        res = m_pc + 4; wr = 1'b1;
        nxt = m_pc + int'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      end
      7'h67: begin res = m_pc + 4; wr = 1'b1; nxt = (a + ii) & 32'hFFFF_FFFE; end
      7'h63: begin
        case (ins[14:12])
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: tk = 1'b0;
        endcase
        if (tk) nxt = m_pc + int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      end
      7'h03: begin y = a + ii; res = m_ram[y[9:2]]; wr = 1'b1; end
      7'h23: begin
        e.we = 1'b1;
        e.addr = a + int'($signed({ins[31:25], ins[11:7]}));
        e.data = b;
        m_ram[e.addr[9:2]] = b;
      end
      7'h13, 7'h33: begin
        y  = (op == 7'h13) ? ii : b;
        sh = y[4:0];
        wr = 1'b1;
        case (ins[14:12])
          3'd0: res = (op == 7'h33 && ins[30]) ? a - y : a + y;
          3'd1: res = a << sh;
          3'd2: res = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
          3'd3: res = (a < y) ? 32'd1 : 32'd0;
          3'd4: res = a ^ y;
          3'd5: res = ins[30] ? 32'($signed(a) >>> sh) : a >> sh;
          3'd6: res = a | y;
          default: res = a & y;
        endcase
      end
      default: ;
    endcase
    if (wr && rd != 5'd0) m_reg[rd] = res;
    m_pc = nxt;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("pc", rom_addr, mon_e.pc);
      check("mem_wr_sig", {31'b0, mem_wr_sig}, {31'b0, mon_e.we});
      if (mon_e.we) begin
        check("mem_addr", mem_addr, mon_e.addr);
        check("mem_wr_data", mem_wr_data, mon_e.data);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic prepare();
    reset = 1'b1;
    ram_clr = 1'b1;
    @(posedge clk);
    #1 ram_clr = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
  endtask

  task automatic run_prog(input int nsteps);
    exp_t e;
    int   cyc;
    m_pc = RST_PC;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    for (int i = 0; i < 256; i++) m_ram[i] = 32'h0;
    exp_q.delete();
    for (int k = 0; k < nsteps; k++) begin
      model_step(e);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    check("reset_rom_addr", rom_addr, RST_PC);
    check("reset_wr_sig", {31'b0, mem_wr_sig}, 32'h0);
    for (int i = 0; i < 32; i++)
      check($sformatf("reset_x%0d", i), dut.reg_file_inst.registers[i], 32'h0);
    reset = 1'b0;
    mon_en = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < nsteps + 8) begin
      @(posedge clk);
      cyc++;
    end
    check("trace_drained", exp_q.size(), 32'h0);
    #1 mon_en = 1'b0;
    for (int i = 0; i < 32; i++)
      check($sformatf("x%0d", i), dut.reg_file_inst.registers[i], m_reg[i]);
  endtask

  // Asynchronous reset asserted mid-cycle while clk is high.
  task automatic mid_reset_check();
    #1 reset = 1'b1;
    #1;
    check("async_reset_pc", rom_addr, RST_PC);
    check("async_reset_wr_sig", {31'b0, mem_wr_sig}, 32'h0);
    check("async_reset_x1", dut.reg_file_inst.registers[1], 32'h0);
    check("async_reset_x10", dut.reg_file_inst.registers[10], 32'h0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm, w;
    int          off;
    rd  = 5'($urandom_range(0, 31));
    rs1 = 5'($urandom_range(0, 31));
    rs2 = 5'($urandom_range(0, 31));
    f3  = 3'($urandom_range(0, 7));
    imm = $urandom();
    case ($urandom_range(0, 11))
      0, 1, 2: w = enc_i(imm, rs1, f3, rd, 7'h13);
      3, 4:    w = enc_r(($urandom_range(0, 3) == 0) ? 7'($urandom()) :
                         {1'b0, 1'($urandom_range(0, 1)), 5'b0}, rs2, rs1, f3, rd);
      5:       w = enc_u(imm, rd, ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17);
      6:       w = enc_i({24'b0, 6'($urandom_range(0, 63)), 2'b0}, rs1, f3, rd, 7'h03);
      7:       w = enc_s({24'b0, 6'($urandom_range(0, 63)), 2'b0}, rs2, rs1, f3);
      8: begin
        off = (int'($urandom_range(0, 12)) - 4) * 4;
        w = enc_b(off, rs2, rs1, f3);
      end
      9: begin
        off = (int'($urandom_range(0, 8)) - 2) * 4;
        w = enc_j(off, rd);
      end
      10: w = enc_i({20'b0, 12'($urandom_range(0, 255))}, rs1, 3'd0, rd, 7'h67);
      default: begin
        case ($urandom_range(0, 3))
          0: w = 32'h0000_0000;
          1: w = 32'h0000_000f;
          2: w = 32'h0000_0073;
          default: w = $urandom();
        endcase
      end
    endcase
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed program: ALU, store/load, branches, jumps, x0, NOP opcodes
    prepare();
    rom[0]  = enc_i(5, 0, 3'd0, 1, 7'h13);
    rom[1]  = enc_i(-3, 0, 3'd0, 2, 7'h13);
    rom[2]  = enc_r(7'h00, 2, 1, 3'd0, 3);
    rom[3]  = enc_r(7'h20, 1, 2, 3'd0, 4);
    rom[4]  = enc_r(7'h00, 1, 2, 3'd2, 5);
    rom[5]  = enc_r(7'h00, 1, 2, 3'd3, 6);
    rom[6]  = enc_s(8, 1, 0, 3'd2);
    rom[7]  = enc_i(8, 0, 3'd2, 7, 7'h03);
    rom[8]  = enc_b(8, 1, 1, 3'd0);
    rom[9]  = enc_i(1, 0, 3'd0, 8, 7'h13);
    rom[10] = enc_b(8, 1, 1, 3'd1);
    rom[11] = enc_i(2, 0, 3'd0, 9, 7'h13);
    rom[12] = enc_j(8, 1);
    rom[13] = enc_j(12, 0);
    rom[14] = enc_i(3, 0, 3'd0, 11, 7'h13);
    rom[15] = enc_i(0, 1, 3'd0, 0, 7'h67);
    rom[16] = 32'h0000_0073;
    rom[17] = 32'h0000_000f;
    rom[18] = 32'h0000_0000;
    rom[19] = enc_i(7, 0, 3'd0, 0, 7'h13);
    rom[20] = enc_j(0, 0);
    run_prog(40);
    check("add_x3", dut.reg_file_inst.registers[3], 32'd2);
    check("sub_x4", dut.reg_file_inst.registers[4], 32'hFFFF_FFF8);
    check("slt_x5", dut.reg_file_inst.registers[5], 32'd1);
    check("sltu_x6", dut.reg_file_inst.registers[6], 32'd0);
    check("lw_x7", dut.reg_file_inst.registers[7], 32'd5);
    check("beq_skip_x8", dut.reg_file_inst.registers[8], 32'd0);
    check("bne_fall_x9", dut.reg_file_inst.registers[9], 32'd2);
    check("jal_link_x1", dut.reg_file_inst.registers[1], 32'd52);
    check("jal_target_x11", dut.reg_file_inst.registers[11], 32'd3);
    check("x0_zero", dut.reg_file_inst.registers[0], 32'd0);
    check("ram_word2", ram[2], 32'd5);
    check("halt_pc", rom_addr, 32'd80);
    mid_reset_check();

    // Recursive sum of 1..10 with the stack in RAM
    prepare();
    rom[0]  = enc_i(1024, 0, 3'd0, 2, 7'h13);
    rom[1]  = enc_i(10, 0, 3'd0, 10, 7'h13);
    rom[2]  = enc_j(12, 1);
    rom[3]  = enc_i(0, 10, 3'd0, 29, 7'h13);
    rom[4]  = enc_j(0, 0);
    rom[5]  = enc_i(-8, 2, 3'd0, 2, 7'h13);
    rom[6]  = enc_s(4, 1, 2, 3'd2);
    rom[7]  = enc_s(0, 10, 2, 3'd2);
    rom[8]  = enc_b(12, 0, 10, 3'd1);
    rom[9]  = enc_i(8, 2, 3'd0, 2, 7'h13);
    rom[10] = enc_i(0, 1, 3'd0, 0, 7'h67);
    rom[11] = enc_i(-1, 10, 3'd0, 10, 7'h13);
    rom[12] = enc_j(-28, 1);
    rom[13] = enc_i(0, 2, 3'd2, 5, 7'h03);
    rom[14] = enc_i(4, 2, 3'd2, 1, 7'h03);
    rom[15] = enc_r(7'h00, 5, 10, 3'd0, 10);
    rom[16] = enc_i(8, 2, 3'd0, 2, 7'h13);
    rom[17] = enc_i(0, 1, 3'd0, 0, 7'h67);
    run_prog(450);
    check("sum_x29", dut.reg_file_inst.registers[29], 32'd55);
    mid_reset_check();

    // Random programs filling the whole ROM
    for (int p = 0; p < 4; p++) begin
      prepare();
      for (int i = 0; i < 256; i++) rom[i] = rand_instr();
      run_prog(300);
    end
    mid_reset_check();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
